// File: rtl/pixel_pkg.sv
// Shared pixel types and default frame constants for the
// UART pixel assembler slice.
package pixel_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    PH_R,
    PH_G,
    PH_B
  } byte_phase_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_HEIGHT  = 8;
  localparam int DEF_TIMEOUT = 17360;

endpackage

// File: rtl/byte_timeout.sv
// Idle counter: counts while run, clears on clear, expire is
// high on the LIMIT-th consecutive run cycle (pclk, rst_n, run, clear -> expire).
module byte_timeout
  import pixel_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expire = run && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_pixel_assembler.sv
// Packs R,G,B bytes into 24-bit pixels with sof/eol/eof flags.
// Ports: byte in (in_*), pixel out (pix_*), frame_done, resync; macro PIXEL_TIMEOUT_EN.
module uart_pixel_assembler
  import pixel_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int HEIGHT         = DEF_HEIGHT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        frame_done,
  output logic        resync
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  byte_phase_t   phase;
  logic [15:0]   hold;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic          acc, out_hs;
  logic          last_x, last_y;
  logic          expire;
  rgb_t          px;

  assign in_ready = (phase != PH_B) || !pix_valid || pix_ready;
  assign acc      = in_valid && in_ready;
  assign out_hs   = pix_valid && pix_ready;
  assign last_x   = (x == XW'(WIDTH - 1));
  assign last_y   = (y == YW'(HEIGHT - 1));
  assign px       = rgb_t'({hold, in_data});

  // Position of the next pixel to load: advanced past a
  // pixel leaving in this same cycle.
  always_comb begin
    nx = x;
    ny = y;
    if (out_hs) begin
      if (last_x) begin
        nx = '0;
        ny = last_y ? '0 : y + 1'b1;
      end else begin
        nx = x + 1'b1;
      end
    end
  end

`ifdef PIXEL_TIMEOUT_EN
  byte_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .run    ((phase != PH_R) && !acc),
    .clear  ((phase == PH_R) || acc),
    .expire (expire)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) resync <= 1'b0;
    else        resync <= expire;
  end
`else
  assign expire = 1'b0;
  assign resync = 1'b0;
`endif

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= PH_R;
      hold       <= '0;
      x          <= '0;
      y          <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      pix_eof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_hs && pix_eof;
      x          <= nx;
      y          <= ny;
      if (out_hs) pix_valid <= 1'b0;
      if (expire) begin
        phase <= PH_R;
        hold  <= '0;
      end else if (acc) begin
        unique case (phase)
          PH_R: begin
            hold[15:8] <= in_data;
            phase      <= PH_G;
          end
          PH_G: begin
            hold[7:0] <= in_data;
            phase     <= PH_B;
          end
          PH_B: begin
            phase     <= PH_R;
            pix_data  <= px;
            pix_valid <= 1'b1;
            pix_sof   <= (nx == '0) && (ny == '0);
            pix_eol   <= (nx == XW'(WIDTH - 1));
            pix_eof   <= (nx == XW'(WIDTH - 1)) &&
                         (ny == YW'(HEIGHT - 1));
          end
          default: phase <= PH_R;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_assembler.sv
// Scoreboard bench: byte-level reference model feeds an expected
// pixel queue; a negedge monitor pops and compares on handshakes.
module tb_uart_pixel_assembler;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int TO = 40;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_sof, pix_eol, pix_eof;
  logic        frame_done, resync;

  uart_pixel_assembler #(
    .WIDTH          (W),
    .HEIGHT         (H),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .frame_done (frame_done),
    .resync     (resync)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [23:0] d;
    bit sof, eol, eof;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] part_q[$];
  int pix_idx = 0;
  int tests = 0, fails = 0;
  int rdy_mode = 1;
  int resync_seen = 0, exp_resync = 0;
  int fd_seen = 0, fd_exp_cnt = 0;
  int stalls = 0;
  bit fd_pending = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: every third byte forms a pixel; its raster slot
  // is simply its ordinal within the frame.
  function automatic void model_byte(input logic [7:0] b);
    exp_t e;
    part_q.push_back(b);
    if (part_q.size() == 3) begin
      e.d   = {part_q[0], part_q[1], part_q[2]};
      e.sof = (pix_idx == 0);
      e.eol = ((pix_idx % W) == W - 1);
      e.eof = (pix_idx == W * H - 1);
      exp_q.push_back(e);
      pix_idx = (pix_idx + 1) % (W * H);
      part_q.delete();
    end
  endfunction

  // pix_ready driver: 0, 1 or random, changed just after posedge
  initial forever begin
    @(posedge pclk);
    #1;
    if (rdy_mode == 2) pix_ready = 1'($urandom_range(0, 1));
    else               pix_ready = (rdy_mode == 1);
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (rst_n) begin
        if (fd_pending || frame_done) begin
          chk("frame_done", 32'(frame_done), 32'(fd_pending));
          if (frame_done) fd_seen++;
        end
        fd_pending = 1'b0;
        if (resync) resync_seen++;
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected pixel: got %0h expected none",
                     pix_data);
          end else begin
            e = exp_q.pop_front();
            chk("pix_data", 32'(pix_data), 32'(e.d));
            chk("flags sof/eol/eof",
                32'({pix_sof, pix_eol, pix_eof}),
                32'({e.sof, e.eol, e.eof}));
            if (e.eof) begin
              fd_pending = 1'b1;
              fd_exp_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge pclk);
      if (in_ready) break;
      n++;
      stalls++;
      if (n > 500) begin
        tests++;
        fails++;
        $display("FAIL in_ready wait: got timeout expected accept");
        break;
      end
    end
    @(posedge pclk);
    #1;
    in_valid = 1'b0;
    if (n <= 500) model_byte(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge pclk);
      n++;
    end
    chk("drain pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge pclk);
    #1;
  endtask

  task automatic set_ready(input int m);
    rdy_mode = m;
    @(posedge pclk);
    #2;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, " pix_valid"}, 32'(pix_valid), 32'd0);
    chk({nm, " pix_data"}, 32'(pix_data), 32'd0);
    chk({nm, " flags"},
        32'({pix_sof, pix_eol, pix_eof, frame_done, resync}),
        32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, k;
    logic [7:0] b6;

    repeat (3) @(posedge pclk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge pclk);
    #1;

    // First pixel and its latency
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge pclk);
    chk("latency pix_valid", 32'(pix_valid), 32'd1);
    drain();

    // Complete the frame at full rate, then one more pixel
    s0 = stalls;
    repeat ((W * H - 1) * 3 + 3) send_byte(8'($urandom));
    chk("full-rate stalls", 32'(stalls - s0), 32'd0);
    drain();
    chk("frame_done pulses", 32'(fd_seen), 32'd1);

    // Backpressure: second phase-2 byte must stall
    set_ready(0);
    repeat (5) send_byte(8'($urandom));
    b6 = 8'($urandom);
    in_data  = b6;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp pix_valid", 32'(pix_valid), 32'd1);
      chk("bp pix_data", 32'(pix_data), 32'(exp_q[0].d));
    end
    @(posedge pclk);
    #1;
    rdy_mode = 1;
    send_byte(b6);
    drain();

    // Reset mid-pixel
    send_byte(8'h5A);
    send_byte(8'hA5);
    @(posedge pclk);
    #1;
    rst_n = 1'b0;
    part_q.delete();
    pix_idx = 0;
    #2;
    chk_reset_vals("midreset");
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    drain();

`ifdef PIXEL_TIMEOUT_EN
    // Lone byte followed by silence is discarded
    send_byte(8'h01);
    repeat (TO + 10) @(posedge pclk);
    #1;
    exp_resync++;
    part_q.delete();
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    drain();
`endif

    // Two frames with random backpressure and gaps
    rdy_mode = 2;
    repeat (2 * W * H * 3) begin
      k = $urandom_range(0, 2);
      if (k > 0) begin
        repeat (k) @(posedge pclk);
        #1;
      end
      send_byte(8'($urandom));
    end
    drain();
    set_ready(1);
    drain();

    chk("resync pulses", 32'(resync_seen), 32'(exp_resync));
    chk("frame_done total", 32'(fd_seen), 32'(fd_exp_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
